// File: rtl/seq_signed_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed or unsigned per operation.
// Optional build macro DIV_ABORT_EN adds an abort input that cancels an operation in flight.
module seq_signed_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] pr;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] dnd_orig;
    logic             neg_q;
    logic             neg_r;
    logic             zero_dvs;
    logic             min_by_neg1;
    logic             abort_req;

    logic [WIDTH-1:0] dnd_mag_in;
    logic [WIDTH-1:0] dvs_mag_in;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             fits;

`ifdef DIV_ABORT_EN
    assign abort_req = abort & busy;
`else
    assign abort_req = 1'b0;
`endif

    // Magnitudes; |MIN| stays as the unsigned pattern 2^(WIDTH-1), which is exactly right.
    always_comb begin
        dnd_mag_in = dividend;
        dvs_mag_in = divisor;
        if (signed_mode && dividend[WIDTH-1]) dnd_mag_in = -dividend;
        if (signed_mode && divisor[WIDTH-1])  dvs_mag_in = -divisor;
    end

    // One restoring step: shift in the next dividend bit and keep the difference when it fits.
    always_comb begin
        shifted = {pr, dq[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvs_mag});
        trial   = shifted[WIDTH-1:0] - dvs_mag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (count == CW'(1)) next_state = SIGN;
            SIGN:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort_req) next_state = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            dq          <= '0;
            pr          <= '0;
            dvs_mag     <= '0;
            dnd_orig    <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_dvs    <= 1'b0;
            min_by_neg1 <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort_req) begin
                busy  <= 1'b0;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            dq          <= dnd_mag_in;
                            pr          <= '0;
                            dvs_mag     <= dvs_mag_in;
                            dnd_orig    <= dividend;
                            neg_q       <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            neg_r       <= signed_mode & dividend[WIDTH-1];
                            zero_dvs    <= (divisor == '0);
                            min_by_neg1 <= signed_mode && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                                           && (divisor == '1);
                            count       <= CW'(WIDTH);
                            busy        <= 1'b1;
                        end
                    end
                    CALC: begin
                        dq    <= {dq[WIDTH-2:0], fits};
                        pr    <= fits ? trial : shifted[WIDTH-1:0];
                        count <= count - CW'(1);
                    end
                    SIGN: begin
                        // A zero divisor overrides the iterated result and suppresses overflow.
                        if (zero_dvs) begin
                            quotient    <= '1;
                            remainder   <= dnd_orig;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end else begin
                            quotient    <= neg_q ? -dq : dq;
                            remainder   <= neg_r ? -pr : pr;
                            div_by_zero <= 1'b0;
                            overflow    <= min_by_neg1;
                        end
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                    default: begin
                        busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
